// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - handshake bundle for the decode-stage immediate generator
//
// Purpose: groups the input-side and output-side valid/ready channels of
//          imm_gen_pipe into one interface.
// Ports (signals):
//    in_valid/in_ready         input entry handshake
//    in_instr[24:0]            instruction bits [31:7]
//    in_immsrc[2:0]            immediate select code
//    in_pc[XLEN-1:0]           PC of the instruction
//    out_valid/out_ready       output entry handshake
//    out_immext[XLEN-1:0]      sign-extended immediate
//    out_target[XLEN-1:0]      precomputed branch/jump target
//    out_immsrc[2:0]           registered select code
//    out_illegal               select code was 110/111
// Modports: master = producer/consumer around the block, slave = imm_gen_pipe.
interface imm_gen_pipe_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [24:0]     in_instr;
   logic [2:0]      in_immsrc;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_immext;
   logic [XLEN-1:0] out_target;
   logic [2:0]      out_immsrc;
   logic            out_illegal;

   modport master (
      output in_valid, in_instr, in_immsrc, in_pc, out_ready,
      input  in_ready, out_valid, out_immext, out_target, out_immsrc, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_immsrc, in_pc, out_ready,
      output in_ready, out_valid, out_immext, out_target, out_immsrc, out_illegal
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with 2-entry skid buffer
//
// Purpose: decodes the immediate for I/S/B/J/U formats, sign-extends it to
//          XLEN, optionally precomputes the branch/jump target, and registers
//          the result behind a valid/ready handshake with a main + skid entry.
// Ports:
//    clk       clock, rising edge
//    rst_n     asynchronous active-low reset
//    flush     synchronous kill of both buffered entries (beats accept/drain)
//    bus       imm_gen_pipe_if.slave (see interface file for signal list)
// Configuration:
//    IMM_TARGET_EN  when defined, builds the target adder and target registers;
//                   otherwise out_target is tied to 0 and in_pc is unused.
module imm_gen_pipe #(
   parameter int XLEN = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   imm_gen_pipe_if.slave bus
);

   logic [24:0]     ins;
   logic            sgn;
   logic [XLEN-1:0] imm_d;
   logic            ill_d;

   // ins[k] holds instruction bit k+7
   assign ins = bus.in_instr;
   assign sgn = ins[24];

   always_comb begin
      imm_d = '0;
      ill_d = 1'b0;
      case (bus.in_immsrc)
         3'b000:         imm_d = {{(XLEN-12){sgn}}, ins[24:13]};
         3'b001:         imm_d = {{(XLEN-12){sgn}}, ins[24:18], ins[4:0]};
         3'b010:         imm_d = {{(XLEN-13){sgn}}, ins[24], ins[0], ins[23:18], ins[4:1], 1'b0};
         3'b011:         imm_d = {{(XLEN-21){sgn}}, ins[24], ins[12:5], ins[13], ins[23:14], 1'b0};
         // U-type: bit 31 is the sign, so replicate it and append bits 30:12
         3'b100, 3'b101: imm_d = {{(XLEN-31){sgn}}, ins[23:5], 12'b0};
         default:        ill_d = 1'b1;
      endcase
   end

`ifdef IMM_TARGET_EN
   logic [XLEN-1:0] tgt_d;
   logic [XLEN-1:0] main_tgt_q;
   logic [XLEN-1:0] skid_tgt_q;

   always_comb begin
      tgt_d = bus.in_pc + imm_d;
      if (ill_d)
         tgt_d = bus.in_pc;
      else if (bus.in_immsrc == 3'b101)
         tgt_d = imm_d;
   end
`endif

   logic            main_valid_q;
   logic [XLEN-1:0] main_imm_q;
   logic [2:0]      main_src_q;
   logic            main_ill_q;
   logic            skid_valid_q;
   logic [XLEN-1:0] skid_imm_q;
   logic [2:0]      skid_src_q;
   logic            skid_ill_q;
   logic            accept;
   logic            drain;

   assign accept = bus.in_valid & ~skid_valid_q;
   assign drain  = main_valid_q & bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_imm_q   <= '0;
         main_src_q   <= 3'b000;
         main_ill_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= '0;
         skid_src_q   <= 3'b000;
         skid_ill_q   <= 1'b0;
`ifdef IMM_TARGET_EN
         main_tgt_q   <= '0;
         skid_tgt_q   <= '0;
`endif
      end else if (flush) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else if (main_valid_q && !drain) begin
         // stalled: main holds steady, a new entry parks in the skid slot
         if (accept) begin
            skid_valid_q <= 1'b1;
            skid_imm_q   <= imm_d;
            skid_src_q   <= bus.in_immsrc;
            skid_ill_q   <= ill_d;
`ifdef IMM_TARGET_EN
            skid_tgt_q   <= tgt_d;
`endif
         end
      end else if (skid_valid_q) begin
         // in_ready is low here, so no accept competes with the skid refill
         main_valid_q <= 1'b1;
         main_imm_q   <= skid_imm_q;
         main_src_q   <= skid_src_q;
         main_ill_q   <= skid_ill_q;
         skid_valid_q <= 1'b0;
`ifdef IMM_TARGET_EN
         main_tgt_q   <= skid_tgt_q;
`endif
      end else begin
         main_valid_q <= accept;
         if (accept) begin
            main_imm_q <= imm_d;
            main_src_q <= bus.in_immsrc;
            main_ill_q <= ill_d;
`ifdef IMM_TARGET_EN
            main_tgt_q <= tgt_d;
`endif
         end
      end
   end

   assign bus.in_ready    = ~skid_valid_q;
   assign bus.out_valid   = main_valid_q;
   assign bus.out_immext  = main_imm_q;
   assign bus.out_immsrc  = main_src_q;
   assign bus.out_illegal = main_ill_q;
`ifdef IMM_TARGET_EN
   assign bus.out_target  = main_tgt_q;
`else
   assign bus.out_target  = '0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe (XLEN 32 and 64 in lockstep)
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic flush;

   imm_gen_pipe_if #(.XLEN(32)) b32 ();
   imm_gen_pipe_if #(.XLEN(64)) b64 ();

   imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32.slave));
   imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64.slave));

   typedef struct {
      logic [63:0] imm;
      logic [63:0] tgt;
      logic [2:0]  sel;
      logic        ill;
   } ent_t;

   ent_t q[$];
   int   total = 0;
   int   bad   = 0;
   logic last_acc;
   logic last_drn;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [24:0] fld(input logic [31:0] w);
      return w[31:7];
   endfunction

   // Reference: rebuild the full instruction word and apply the format rules
   function automatic ent_t ref_ent(input logic [24:0] ii, input logic [2:0] sel,
                                    input logic [63:0] pc);
      ent_t        e;
      logic [31:0] w;
      longint      v;
      w = {ii, 7'b0};
      case (sel)
         3'd0:       v = longint'($signed(w[31:20]));
         3'd1:       v = longint'($signed({w[31:25], w[11:7]}));
         3'd2:       v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
         3'd3:       v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
         3'd4, 3'd5: v = longint'($signed({w[31:12], 12'b0}));
         default:    v = 0;
      endcase
      e.imm = v;
      e.sel = sel;
      e.ill = (sel >= 3'd6);
`ifdef IMM_TARGET_EN
      if (e.ill)          e.tgt = pc;
      else if (sel == 3'd5) e.tgt = e.imm;
      else                e.tgt = pc + e.imm;
`else
      e.tgt = 64'd0;
`endif
      return e;
   endfunction

   task automatic drive(input logic v, input logic [24:0] ii, input logic [2:0] sel,
                        input logic [63:0] pc, input logic rdy, input logic fl);
      b32.in_valid  = v;      b64.in_valid  = v;
      b32.in_instr  = ii;     b64.in_instr  = ii;
      b32.in_immsrc = sel;    b64.in_immsrc = sel;
      b32.in_pc     = pc[31:0];
      b64.in_pc     = pc;
      b32.out_ready = rdy;    b64.out_ready = rdy;
      flush         = fl;
   endtask

   task automatic check_out();
      chk("in_ready32", b32.in_ready, q.size() < 2);
      chk("in_ready64", b64.in_ready, q.size() < 2);
      chk("out_valid32", b32.out_valid, q.size() > 0);
      chk("out_valid64", b64.out_valid, q.size() > 0);
      if (q.size() > 0) begin
         chk("immext32", b32.out_immext, q[0].imm[31:0]);
         chk("immext64", b64.out_immext, q[0].imm);
         chk("target32", b32.out_target, q[0].tgt[31:0]);
         chk("target64", b64.out_target, q[0].tgt);
         chk("immsrc32", b32.out_immsrc, q[0].sel);
         chk("immsrc64", b64.out_immsrc, q[0].sel);
         chk("illegal32", b32.out_illegal, q[0].ill);
         chk("illegal64", b64.out_illegal, q[0].ill);
      end
   endtask

   // Called at a falling edge: drive inputs, advance the model across the
   // coming rising edge, then check at the next falling edge.
   task automatic step(input logic v, input logic [24:0] ii, input logic [2:0] sel,
                       input logic [63:0] pc, input logic rdy, input logic fl);
      int n;
      drive(v, ii, sel, pc, rdy, fl);
      n = q.size();
      last_acc = 1'b0;
      last_drn = 1'b0;
      if (fl) begin
         q.delete();
      end else begin
         last_acc = v && (n < 2);
         last_drn = rdy && (n > 0);
         if (last_drn) void'(q.pop_front());
         if (last_acc) q.push_back(ref_ent(ii, sel, pc));
      end
      @(negedge clk);
      check_out();
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_valid32"}, b32.out_valid, 0);
      chk({tag, "_ready32"}, b32.in_ready, 1);
      chk({tag, "_imm32"}, b32.out_immext, 0);
      chk({tag, "_tgt32"}, b32.out_target, 0);
      chk({tag, "_src32"}, b32.out_immsrc, 0);
      chk({tag, "_ill32"}, b32.out_illegal, 0);
      chk({tag, "_valid64"}, b64.out_valid, 0);
      chk({tag, "_imm64"}, b64.out_immext, 0);
      chk({tag, "_tgt64"}, b64.out_target, 0);
   endtask

   logic [24:0] bp_i[4];
   int          idx;
   int          drains;

   initial begin
      rst_n = 1'b0;
      drive(1'b0, '0, 3'd0, 64'd0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;

      // directed formats
      step(1'b1, fld(32'hFFF00093), 3'd0, 64'h0, 1'b1, 1'b0);
      chk("i_imm", b32.out_immext, 64'hFFFFFFFF);
      chk("i_ill", b32.out_illegal, 0);
      step(1'b1, fld(32'hFE000EE3), 3'd2, 64'h100, 1'b1, 1'b0);
      chk("b_imm", b32.out_immext, 64'hFFFFFFFC);
`ifdef IMM_TARGET_EN
      chk("b_tgt", b32.out_target, 64'hFC);
`endif
      step(1'b1, fld(32'h80000037), 3'd5, 64'h1234, 1'b1, 1'b0);
      chk("lui_imm64", b64.out_immext, 64'hFFFFFFFF80000000);
`ifdef IMM_TARGET_EN
      chk("lui_tgt64", b64.out_target, 64'hFFFFFFFF80000000);
`endif
      step(1'b1, 25'($urandom), 3'd6, 64'h40, 1'b1, 1'b0);
      chk("ill_imm", b32.out_immext, 0);
      chk("ill_flag", b32.out_illegal, 1);
`ifdef IMM_TARGET_EN
      chk("ill_tgt", b32.out_target, 64'h40);
`endif
      step(1'b0, '0, 3'd0, 64'd0, 1'b1, 1'b0);

      // backpressure: out_ready low for 4 cycles, then high
      for (int k = 0; k < 4; k++) bp_i[k] = 25'($urandom);
      idx    = 0;
      drains = 0;
      for (int c = 0; c < 20 && (idx < 4 || q.size() > 0); c++) begin
         step(idx < 4, bp_i[(idx < 4) ? idx : 0], 3'(idx % 6), 64'(32'h1000 + idx * 4),
              c >= 4, 1'b0);
         if (last_acc) idx++;
         if (last_drn) drains++;
         if (c == 1) chk("bp_in_ready", b32.in_ready, 0);
      end
      chk("bp_accepted", idx, 4);
      chk("bp_drained", drains, 4);

      // flush with both entries full and an entry offered
      step(1'b0, '0, 3'd0, 64'd0, 1'b1, 1'b0);
      step(1'b1, 25'($urandom), 3'd0, 64'h200, 1'b0, 1'b0);
      step(1'b1, 25'($urandom), 3'd1, 64'h204, 1'b0, 1'b0);
      chk("fl_full", b32.in_ready, 0);
      step(1'b1, 25'($urandom), 3'd2, 64'h208, 1'b0, 1'b1);
      chk("fl_valid", b32.out_valid, 0);
      chk("fl_ready", b32.in_ready, 1);

      // asynchronous reset mid-stream
      step(1'b1, 25'($urandom), 3'd3, 64'h300, 1'b0, 1'b0);
      drive(1'b0, '0, 3'd0, 64'd0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      check_out();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, 25'($urandom), 3'($urandom_range(0, 7)),
              {$urandom, $urandom}, ($urandom % 3) != 0, ($urandom % 40) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
